// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel one-shot timer.
package timer_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } timer_state_t;

  // True when exactly one bit of vec is set.
  function automatic logic is_onehot(input logic [63:0] vec);
    return (vec != 64'd0) && ((vec & (vec - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: latches a period on an accepted trigger, counts it out
// and emits a registered single-cycle done pulse.
//   state    | meaning
//   IDLE     | waiting for an accepted trigger
//   COUNTING | counting cnt from 0 up to per-1
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int RETRIG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc,
  input  logic             cancel,
  input  logic [CNT_W-1:0] period,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  timer_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] period_eff;

  // A zero period would never terminate, so it is treated as one cycle.
  assign period_eff = (period == '0) ? ONE : period;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && !cancel) begin
          state_d = COUNTING;
          cnt_d   = '0;
          per_d   = period_eff;
        end
      end
      COUNTING: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((RETRIG != 0) && acc) begin
          cnt_d = '0;
          per_d = period_eff;
        end else if (cnt_q == per_q - ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == COUNTING);
  assign done = done_q;

endmodule

// File: rtl/multi_oneshot_timer.sv
// N-channel one-shot interval timer: trigger acceptance decode plus one
// timer_channel per channel. N_CH is limited to 64 by the one-hot helper.
module multi_oneshot_timer
  import timer_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int EXCLUSIVE = 1,
  parameter int RETRIG    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       trig,
  input  logic [N_CH-1:0]       cancel,
  input  logic [N_CH*CNT_W-1:0] period,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done
);

  logic [63:0]     trig_ext;
  logic            trig_onehot;
  logic [N_CH-1:0] acc;

  assign trig_ext    = 64'(trig);
  assign trig_onehot = is_onehot(trig_ext);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign acc[gi] = (EXCLUSIVE != 0) ? (trig[gi] & trig_onehot) : trig[gi];

    timer_channel #(
      .CNT_W  (CNT_W),
      .RETRIG (RETRIG)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .acc    (acc[gi]),
      .cancel (cancel[gi]),
      .period (period[gi*CNT_W +: CNT_W]),
      .busy   (busy[gi]),
      .done   (done[gi])
    );
  end

endmodule

// File: tb/tb_multi_oneshot_timer.sv
// Directed bench for multi_oneshot_timer: three configurations share one set
// of inputs (A: exclusive/no retrig, B: independent, C: exclusive/retrig).
module tb_multi_oneshot_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  trig;
  logic [3:0]  cancel;
  logic [63:0] period;
  logic [3:0]  busy_a, done_a, busy_b, done_b, busy_c, done_c;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multi_oneshot_timer #(.N_CH(4), .CNT_W(16), .EXCLUSIVE(1), .RETRIG(0)) dut_a (
    .clk(clk), .reset(reset), .trig(trig), .cancel(cancel), .period(period),
    .busy(busy_a), .done(done_a));

  multi_oneshot_timer #(.N_CH(4), .CNT_W(16), .EXCLUSIVE(0), .RETRIG(0)) dut_b (
    .clk(clk), .reset(reset), .trig(trig), .cancel(cancel), .period(period),
    .busy(busy_b), .done(done_b));

  multi_oneshot_timer #(.N_CH(4), .CNT_W(16), .EXCLUSIVE(1), .RETRIG(1)) dut_c (
    .clk(clk), .reset(reset), .trig(trig), .cancel(cancel), .period(period),
    .busy(busy_c), .done(done_c));

  typedef struct {
    logic       rst;
    logic [3:0] trig;
    logic [3:0] exp_busy;
    logic [3:0] exp_done;
  } vec_t;

  vec_t vecs[64];
  int   n_vecs = 0;

  task automatic add(input logic r, input logic [3:0] t, input logic [3:0] b, input logic [3:0] d);
    vecs[n_vecs].rst      = r;
    vecs[n_vecs].trig     = t;
    vecs[n_vecs].exp_busy = b;
    vecs[n_vecs].exp_done = d;
    n_vecs++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    trig   = '0;
    cancel = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int lat, nbusy, first_a, first_c, cnt_a, cnt_c;
    logic seen;

    reset  = 1'b1;
    trig   = '0;
    cancel = '0;
    period = '0;
    step();
    step();
    check("reset_busy_a", 32'(busy_a), 32'h0);
    check("reset_done_a", 32'(done_a), 32'h0);
    check("reset_outs_bc", 32'({busy_b, done_b, busy_c, done_c}), 32'h0);
    reset = 1'b0;

    // ch3=1, ch2=0, ch1=7, ch0=5
    period = {16'd1, 16'd0, 16'd7, 16'd5};
    add(0, 4'b0001, 4'b0001, 4'b0000);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) add(0, 4'b0011, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0100, 4'b0100, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0100);
    add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b1000, 4'b1000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b1000);
    add(0, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0001, 4'b0000);
    add(0, 4'b0000, 4'b0001, 4'b0000);
    add(1, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 7; i++) add(0, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < n_vecs; i++) begin
      reset = vecs[i].rst;
      trig  = vecs[i].trig;
      step();
      check($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(done_a), 32'(vecs[i].exp_done));
    end
    reset = 1'b0;

    // Overlapping trigger: independent channels start, exclusive ones do not.
    do_reset();
    period = {16'd0, 16'd0, 16'd6, 16'd3};
    for (int k = 1; k <= 10; k++) begin
      trig = (k <= 3) ? 4'b0011 : 4'b0000;
      step();
      check($sformatf("indep_k%0d_busy", k), 32'(busy_b),
            32'({2'b00, (k <= 6), (k <= 3)}));
      check($sformatf("indep_k%0d_done", k), 32'(done_b),
            32'({2'b00, (k == 7), (k == 4)}));
      check($sformatf("excl_k%0d_idle", k), 32'({busy_a, done_a}), 32'h0);
    end

    // Full-scale period: done after 65536 edges, busy for 65535 cycles.
    do_reset();
    period = {48'd0, 16'hFFFF};
    trig = 4'b0001;
    step();
    trig  = 4'b0000;
    lat   = 1;
    nbusy = 0;
    while (done_a[0] !== 1'b1 && lat < 70000) begin
      if (busy_a[0]) nbusy++;
      step();
      lat++;
    end
    check("max_latency", 32'(lat), 32'd65536);
    check("max_busy_cycles", 32'(nbusy), 32'd65535);
    check("max_busy_after_done", 32'(busy_a[0]), 32'h0);

    // Cancel at count 4 of a 10-cycle period.
    do_reset();
    period = {48'd0, 16'd10};
    trig = 4'b0001;
    step();
    trig = 4'b0000;
    for (int k = 2; k <= 5; k++) step();
    cancel = 4'b0001;
    step();
    cancel = 4'b0000;
    check("cancel_busy", 32'(busy_a[0]), 32'h0);
    seen = done_a[0];
    for (int k = 0; k < 10; k++) begin
      step();
      seen = seen | done_a[0];
    end
    check("cancel_no_done", 32'(seen), 32'h0);

    // Retrigger at count 4 with new period 3 (also a period change for A).
    do_reset();
    period = {48'd0, 16'd10};
    trig = 4'b0001;
    step();
    trig = 4'b0000;
    for (int k = 2; k <= 5; k++) step();
    period = {48'd0, 16'd3};
    trig = 4'b0001;
    first_a = 0; first_c = 0; cnt_a = 0; cnt_c = 0;
    for (int k = 6; k <= 20; k++) begin
      step();
      trig = 4'b0000;
      if (done_a[0]) begin cnt_a++; if (first_a == 0) first_a = k; end
      if (done_c[0]) begin cnt_c++; if (first_c == 0) first_c = k; end
    end
    check("retrig_done_k", 32'(first_c), 32'd9);
    check("retrig_done_count", 32'(cnt_c), 32'd1);
    check("noretrig_done_k", 32'(first_a), 32'd11);
    check("noretrig_done_count", 32'(cnt_a), 32'd1);

    // Trigger held with P=2: two busy cycles then one done cycle, repeating.
    do_reset();
    period = {32'd0, 16'd2, 16'd0};
    trig = 4'b0010;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("b2b_k%0d_busy", k), 32'(busy_a), 32'({2'b00, (k % 3 != 0), 1'b0}));
      check($sformatf("b2b_k%0d_done", k), 32'(done_a), 32'({2'b00, (k % 3 == 0), 1'b0}));
    end
    trig = 4'b0000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
